pci_target_ctrl: RTL

PCI target data-phase controller for the slave. Sits directly downstream of the DEVSEL# generator (`devSelect`) and consumes its `devSelect` output. It decodes the command on the address phase, drives TRDY#/STOP# and the AD output enable, and executes single and burst memory reads/writes against a 4-word, 32-bit internal register file with byte-enable masking.

---
 rtl/pci_target_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pci_target_ctrl.sv
// PCI target data-phase controller: decodes memory read/write commands, drives TRDY#/STOP#/AD enable
// and runs single or burst transfers against a small byte-maskable register file.
module pci_target_ctrl #(
    parameter int WORDS          = 4,
    parameter int DEVSEL_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        irdy,
    input  logic        devsel,
    input  logic [3:0]  cbe,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        trdy,
    output logic        stop
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WAIT_DEVSEL = 3'd1;
    localparam logic [2:0] READ_TA     = 3'd2;
    localparam logic [2:0] DATA        = 3'd3;
    localparam logic [2:0] DISCONNECT  = 3'd4;
    localparam logic [2:0] TURN        = 3'd5;
    localparam logic [2:0] IGNORE      = 3'd6;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    // Byte enables are active low: a 0 in beN[i] replaces byte i.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  beN);
        logic [31:0] w;
        w = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (!beN[i]) begin
                w[8*i +: 8] = newWord[8*i +: 8];
            end else begin
                w[8*i +: 8] = oldWord[8*i +: 8];
            end
        end
        return w;
    endfunction

    logic [2:0]  state;
    logic [2:0]  stateNext;
    logic        frameQ;
    logic [3:0]  cmd;
    logic [3:0]  cmdNext;
    logic [1:0]  idx;
    logic [1:0]  idxNext;
    logic [3:0]  waitCnt;
    logic [3:0]  waitCntNext;
    logic [31:0] mem [WORDS];

    logic        addrPhase;
    logic        isRead;
    logic        xfer;
    logic        wrEn;
    logic [31:0] wrWord;
    logic        oeNext;
    logic [31:0] rdWord;

    assign addrPhase = !frame && frameQ;
    assign isRead    = (cmd == CMD_MEM_RD);
    assign xfer      = (state == DATA) && !irdy && !trdy;
    assign wrEn      = xfer && !isRead;
    assign wrWord    = mergeBytes(mem[idx], ad_in, cbe);

    // Next-state, index, command and DEVSEL# wait counter
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        cmdNext     = cmd;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (addrPhase) begin
                    cmdNext     = cbe;
                    idxNext     = ad_in[3:2];
                    waitCntNext = 4'd0;
                    if ((cbe == CMD_MEM_RD) || (cbe == CMD_MEM_WR)) begin
                        stateNext = WAIT_DEVSEL;
                    end else begin
                        stateNext = IGNORE;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            WAIT_DEVSEL: begin
                if (!devsel) begin
                    stateNext = isRead ? READ_TA : DATA;
                end else if (waitCnt == 4'(DEVSEL_TIMEOUT - 1)) begin
                    stateNext = IGNORE;
                end else begin
                    waitCntNext = waitCnt + 4'd1;
                end
            end
            READ_TA: stateNext = DATA;
            DATA: begin
                if (xfer) begin
                    if (frame) begin
                        stateNext = TURN;
                    end else if (idx != 2'd3) begin
                        idxNext = idx + 2'd1;
                    end else begin
                        // End of the register file: the index saturates and the master is disconnected.
                        stateNext = DISCONNECT;
                    end
                end else begin
                    stateNext = DATA;
                end
            end
            DISCONNECT: begin
                if (frame) begin
                    stateNext = TURN;
                end else begin
                    stateNext = DISCONNECT;
                end
            end
            TURN: stateNext = IDLE;
            IGNORE: begin
                if (frame && irdy) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = IGNORE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output enable and read data are derived from the next state so they leave the flops directly
    always_comb begin
        oeNext = 1'b0;
        rdWord = mem[idxNext];
        if ((cmdNext == CMD_MEM_RD) &&
            ((stateNext == READ_TA) || (stateNext == DATA) || (stateNext == DISCONNECT))) begin
            oeNext = 1'b1;
        end else begin
            oeNext = 1'b0;
        end
        if (wrEn && (idxNext == idx)) begin
            rdWord = wrWord;
        end else begin
            rdWord = mem[idxNext];
        end
    end

    // State, register file and registered bus outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            frameQ  <= 1'b1;
            cmd     <= 4'd0;
            idx     <= 2'd0;
            waitCnt <= 4'd0;
            trdy    <= 1'b1;
            stop    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= 32'd0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state   <= stateNext;
            frameQ  <= frame;
            cmd     <= cmdNext;
            idx     <= idxNext;
            waitCnt <= waitCntNext;
            trdy    <= (stateNext != DATA);
            stop    <= (stateNext != DISCONNECT);
            ad_oe   <= oeNext;
            if (oeNext) begin
                ad_out <= rdWord;
            end else begin
                ad_out <= ad_out;
            end
            if (wrEn) begin
                mem[idx] <= wrWord;
            end else begin
                mem[idx] <= mem[idx];
            end
        end
    end

endmodule
